// File: rtl/dec_seq_pkg.sv
// rtl/dec_seq_pkg.sv - shared states and control-slave constants for dec_cfg_seq
package dec_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_STOP  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_DIV   = 3'd3,
    ST_RUN   = 3'd4,
    ST_DONE  = 3'd5,
    ST_ABORT = 3'd6
  } dec_seq_state_t;

  localparam logic        CTL_ADDR_RUN = 1'b0;
  localparam logic        CTL_ADDR_DIV = 1'b1;
  localparam logic [31:0] RUN_OFF      = 32'd0;
  localparam logic [31:0] RUN_ON       = 32'd1;

  function automatic logic [31:0] div_word(input logic [1:0] sel);
    return {30'b0, sel};
  endfunction

endpackage

// File: rtl/dec_seq_timer.sv
// rtl/dec_seq_timer.sv - LOAD stall counter; o_expired flags the LIMIT-th consecutive stall cycle
module dec_seq_timer #(
  parameter int LIMIT = 1024
) (
  input  logic i_clk,
  input  logic i_clrn,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_clrn || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expired = i_en && (r_cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/dec_cfg_seq.sv
// rtl/dec_cfg_seq.sv - stops the decoder, loads ENTRIES period words, programs divider, restarts run
// Optional LOAD stall timeout enabled by DEC_SEQ_TIMEOUT_EN.
module dec_cfg_seq
  import dec_seq_pkg::*;
#(
  parameter int M       = 32,
  parameter int ENTRIES = 16,
  parameter int AW      = $clog2(ENTRIES),
  parameter int TIMEOUT = 1024
) (
  input  logic          i_clk,
  input  logic          i_clrn,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic [1:0]    i_div_sel,
  input  logic [M-1:0]  i_cfg_data,
  input  logic          i_cfg_valid,
  output logic          o_cfg_ready,
  output logic          o_ctl_wr,
  output logic          o_ctl_addr,
  output logic [31:0]   o_ctl_wrdata,
  output logic          o_ram_wr,
  output logic [AW-1:0] o_ram_addr,
  output logic [M-1:0]  o_ram_wrdata,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);

  localparam logic [AW-1:0] LAST_IDX = AW'(ENTRIES - 1);

  dec_seq_state_t r_state;
  logic [AW-1:0]  r_idx;
  logic [1:0]     r_div_sel;
  logic           r_cfg_ready;
  logic           r_ctl_wr;
  logic           r_ctl_addr;
  logic [31:0]    r_ctl_wrdata;
  logic           r_ram_wr;
  logic [AW-1:0]  r_ram_addr;
  logic [M-1:0]   r_ram_wrdata;
  logic           r_done;
  logic           r_err;
  logic           w_beat;
  logic           w_expired;

  assign w_beat = i_cfg_valid && r_cfg_ready;

`ifdef DEC_SEQ_TIMEOUT_EN
  logic w_stall_en;
  logic w_stall_clr;

  assign w_stall_en  = (r_state == ST_LOAD) && !w_beat;
  assign w_stall_clr = (r_state != ST_LOAD) || w_beat;

  dec_seq_timer #(.LIMIT(TIMEOUT)) u_timer (
    .i_clk     (i_clk),
    .i_clrn    (i_clrn),
    .i_clr     (w_stall_clr),
    .i_en      (w_stall_en),
    .o_expired (w_expired)
  );
`else
  localparam int unused_timeout = TIMEOUT;
  assign w_expired = 1'b0;
`endif

  // Strobes default low each cycle so every write lasts exactly one cycle.
  always_ff @(posedge i_clk) begin
    if (i_clrn) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_div_sel    <= '0;
      r_cfg_ready  <= 1'b0;
      r_ctl_wr     <= 1'b0;
      r_ctl_addr   <= 1'b0;
      r_ctl_wrdata <= '0;
      r_ram_wr     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wrdata <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_ctl_wr <= 1'b0;
      r_ram_wr <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start && !i_abort) begin
            r_state      <= ST_STOP;
            r_div_sel    <= i_div_sel;
            r_err        <= 1'b0;
            r_idx        <= '0;
            r_ctl_wr     <= 1'b1;
            r_ctl_addr   <= CTL_ADDR_RUN;
            r_ctl_wrdata <= RUN_OFF;
          end
        end
        ST_STOP: begin
          if (i_abort) begin
            r_state <= ST_ABORT;
          end else begin
            r_state     <= ST_LOAD;
            r_cfg_ready <= 1'b1;
          end
        end
        ST_LOAD: begin
          // A handshaken beat is always written, even alongside abort.
          if (w_beat) begin
            r_ram_wr     <= 1'b1;
            r_ram_addr   <= r_idx;
            r_ram_wrdata <= i_cfg_data;
            r_idx        <= r_idx + AW'(1);
          end
          if (i_abort || w_expired) begin
            r_state     <= ST_ABORT;
            r_cfg_ready <= 1'b0;
          end else if (w_beat && (r_idx == LAST_IDX)) begin
            r_state     <= ST_DIV;
            r_cfg_ready <= 1'b0;
          end
        end
        ST_DIV: begin
          if (i_abort) begin
            r_state <= ST_ABORT;
          end else begin
            r_state      <= ST_RUN;
            r_ctl_wr     <= 1'b1;
            r_ctl_addr   <= CTL_ADDR_DIV;
            r_ctl_wrdata <= div_word(r_div_sel);
          end
        end
        ST_RUN: begin
          if (i_abort) begin
            r_state <= ST_ABORT;
          end else begin
            r_state      <= ST_DONE;
            r_ctl_wr     <= 1'b1;
            r_ctl_addr   <= CTL_ADDR_RUN;
            r_ctl_wrdata <= RUN_ON;
          end
        end
        ST_DONE: begin
          if (i_abort) begin
            r_state <= ST_ABORT;
          end else begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        ST_ABORT: begin
          r_state      <= ST_IDLE;
          r_err        <= 1'b1;
          r_ctl_wr     <= 1'b1;
          r_ctl_addr   <= CTL_ADDR_RUN;
          r_ctl_wrdata <= RUN_OFF;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cfg_ready <= 1'b0;
        end
      endcase
    end
  end

  assign o_cfg_ready  = r_cfg_ready;
  assign o_ctl_wr     = r_ctl_wr;
  assign o_ctl_addr   = r_ctl_addr;
  assign o_ctl_wrdata = r_ctl_wrdata;
  assign o_ram_wr     = r_ram_wr;
  assign o_ram_addr   = r_ram_addr;
  assign o_ram_wrdata = r_ram_wrdata;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_done       = r_done;
  assign o_err        = r_err;

endmodule

// File: tb/tb_dec_cfg_seq.sv
// tb/tb_dec_cfg_seq.sv - directed self-checking bench for dec_cfg_seq (timeout case follows DEC_SEQ_TIMEOUT_EN)
module tb_dec_cfg_seq;

  localparam int M       = 32;
  localparam int ENTRIES = 16;
  localparam int AW      = 4;

  logic          clk = 1'b0;
  logic          clrn = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    div_sel = 2'd0;
  logic [M-1:0]  cfg_data = '0;
  logic          cfg_valid = 1'b0;
  logic          o_cfg_ready;
  logic          o_ctl_wr;
  logic          o_ctl_addr;
  logic [31:0]   o_ctl_wrdata;
  logic          o_ram_wr;
  logic [AW-1:0] o_ram_addr;
  logic [M-1:0]  o_ram_wrdata;
  logic          o_busy;
  logic          o_done;
  logic          o_err;

  dec_cfg_seq #(.M(M), .ENTRIES(ENTRIES), .AW(AW), .TIMEOUT(8)) dut (
    .i_clk        (clk),
    .i_clrn       (clrn),
    .i_start      (start),
    .i_abort      (abort),
    .i_div_sel    (div_sel),
    .i_cfg_data   (cfg_data),
    .i_cfg_valid  (cfg_valid),
    .o_cfg_ready  (o_cfg_ready),
    .o_ctl_wr     (o_ctl_wr),
    .o_ctl_addr   (o_ctl_addr),
    .o_ctl_wrdata (o_ctl_wrdata),
    .o_ram_wr     (o_ram_wr),
    .o_ram_addr   (o_ram_addr),
    .o_ram_wrdata (o_ram_wrdata),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] ram_addr_q[$];
  logic [31:0]   ram_data_q[$];
  int            ram_cyc_q[$];
  logic          ctl_addr_q[$];
  logic [31:0]   ctl_data_q[$];
  int            ctl_cyc_q[$];
  int            beat_cyc_q[$];
  int            done_n, done_cyc, busy_low, n0;
  bit            track_busy;
  int            n_checks = 0;
  int            n_errors = 0;

  always @(negedge clk) begin
    if (o_ram_wr) begin
      ram_addr_q.push_back(o_ram_addr);
      ram_data_q.push_back(o_ram_wrdata);
      ram_cyc_q.push_back(cyc);
    end
    if (o_ctl_wr) begin
      ctl_addr_q.push_back(o_ctl_addr);
      ctl_data_q.push_back(o_ctl_wrdata);
      ctl_cyc_q.push_back(cyc);
    end
    if (o_done) begin
      done_n++;
      done_cyc = cyc;
      track_busy = 0;
    end else if (track_busy && !o_busy) begin
      busy_low++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    ram_addr_q.delete(); ram_data_q.delete(); ram_cyc_q.delete();
    ctl_addr_q.delete(); ctl_data_q.delete(); ctl_cyc_q.delete();
    beat_cyc_q.delete();
    done_n = 0; done_cyc = 0; busy_low = 0;
  endtask

  task automatic do_start(input logic [1:0] d);
    @(negedge clk);
    clear_logs();
    start = 1'b1; div_sel = d; n0 = cyc;
    @(negedge clk);
    start = 1'b0;
    track_busy = 1;
  endtask

  // kind 1 = abort, kind 2 = reset, applied once stop_at beats have been accepted
  task automatic feed(input bit toggle, input int stop_at, input int kind, input int poke_at);
    int sent; int guard; bit acc; bit ph; bit poked;
    sent = 0; guard = 0; acc = 0; ph = 1; poked = 0;
    while (sent < ENTRIES && guard < 400) begin
      if (sent == stop_at) begin
        cfg_valid = 1'b0;
        if (kind == 1) abort = 1'b1; else clrn = 1'b1;
        @(negedge clk);
        abort = 1'b0; clrn = 1'b0; track_busy = 0;
        break;
      end
      start = 1'b0;
      if (sent == poke_at && !poked) begin
        start = 1'b1; div_sel = 2'd3; poked = 1;
      end
      cfg_valid = toggle ? ph : 1'b1;
      ph = !ph;
      cfg_data = 32'h10 + sent;
      acc = cfg_valid && o_cfg_ready;
      if (acc) beat_cyc_q.push_back(cyc);
      @(negedge clk);
      if (acc) sent++;
      guard++;
    end
    cfg_valid = 1'b0;
    start = 1'b0;
    if (stop_at < 0) check("feed_beats", sent, ENTRIES);
  endtask

  task automatic wait_idle(input string tag);
    int g;
    g = 0;
    while (o_busy && g < 100) begin
      @(negedge clk);
      g++;
    end
    check(tag, o_busy, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_full(input logic [1:0] d, input bit exact);
    check("ram_count", ram_addr_q.size(), ENTRIES);
    for (int i = 0; i < ENTRIES; i++) begin
      if (i < ram_addr_q.size()) begin
        check($sformatf("ram_addr%0d", i), ram_addr_q[i], i);
        check($sformatf("ram_data%0d", i), ram_data_q[i], 32'h10 + i);
        if (exact) check($sformatf("ram_cyc%0d", i), ram_cyc_q[i], n0 + 3 + i);
        else if (i < beat_cyc_q.size()) check($sformatf("ram_lat%0d", i), ram_cyc_q[i], beat_cyc_q[i] + 1);
      end
    end
    check("ctl_count", ctl_addr_q.size(), 3);
    if (ctl_addr_q.size() == 3) begin
      check("ctl_stop_addr", ctl_addr_q[0], 0);
      check("ctl_stop_data", ctl_data_q[0], 0);
      check("ctl_stop_cyc", ctl_cyc_q[0], n0 + 1);
      check("ctl_div_addr", ctl_addr_q[1], 1);
      check("ctl_div_data", ctl_data_q[1], {30'b0, d});
      check("ctl_run_addr", ctl_addr_q[2], 0);
      check("ctl_run_data", ctl_data_q[2], 1);
    end
    check("done_count", done_n, 1);
    if (exact) check("done_cyc", done_cyc, n0 + 21);
    check("err_ok", o_err, 0);
    check("busy_held", busy_low, 0);
    check("ready_idle", o_cfg_ready, 0);
  endtask

  initial begin
    clear_logs();
    track_busy = 0;
    repeat (2) @(negedge clk);
    check("rst_ready", o_cfg_ready, 0);
    check("rst_ctl_wr", o_ctl_wr, 0);
    check("rst_ctl_addr", o_ctl_addr, 0);
    check("rst_ctl_data", o_ctl_wrdata, 0);
    check("rst_ram_wr", o_ram_wr, 0);
    check("rst_ram_addr", o_ram_addr, 0);
    check("rst_ram_data", o_ram_wrdata, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_err", o_err, 0);
    clrn = 1'b0;
    @(negedge clk);

    // back-to-back load, exact timing
    do_start(2'd2);
    feed(1'b0, -1, 0, -1);
    wait_idle("t1_idle");
    check_full(2'd2, 1'b1);

    // throttled source plus an ignored start during LOAD
    do_start(2'd1);
    feed(1'b1, -1, 0, 8);
    wait_idle("t2_idle");
    check_full(2'd1, 1'b0);
    check("t2_done_late", (done_cyc - n0) >= 31, 1);

    // abort after 5 beats
    do_start(2'd3);
    feed(1'b0, 5, 1, -1);
    wait_idle("t3_idle");
    check("t3_ram_count", ram_addr_q.size(), 5);
    if (ram_addr_q.size() == 5) check("t3_ram_last", ram_addr_q[4], 4);
    check("t3_ctl_count", ctl_addr_q.size(), 2);
    if (ctl_addr_q.size() == 2) begin
      check("t3_abort_addr", ctl_addr_q[1], 0);
      check("t3_abort_data", ctl_data_q[1], 0);
    end
    check("t3_no_done", done_n, 0);
    check("t3_err", o_err, 1);
    do_start(2'd0);
    check("t3_err_clr", o_err, 0);
    feed(1'b0, -1, 0, -1);
    wait_idle("t3b_idle");
    check_full(2'd0, 1'b1);

    // start together with abort in IDLE
    @(negedge clk);
    clear_logs();
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_busy", o_busy, 0);
    check("t4_ctl_count", ctl_addr_q.size(), 0);
    check("t4_err", o_err, 0);

    // reset mid-LOAD at beat 7
    do_start(2'd2);
    feed(1'b0, 7, 2, -1);
    check("t5_ctl_wr", o_ctl_wr, 0);
    check("t5_ram_wr", o_ram_wr, 0);
    check("t5_busy", o_busy, 0);
    check("t5_ready", o_cfg_ready, 0);
    repeat (4) @(negedge clk);
    check("t5_ram_count", ram_addr_q.size(), 7);
    check("t5_ctl_count", ctl_addr_q.size(), 1);
    check("t5_no_done", done_n, 0);
    do_start(2'd1);
    feed(1'b0, -1, 0, -1);
    wait_idle("t5b_idle");
    check_full(2'd1, 1'b1);

    // source stalls in LOAD
    do_start(2'd2);
`ifdef DEC_SEQ_TIMEOUT_EN
    repeat (12) @(negedge clk);
    check("t6_err", o_err, 1);
    check("t6_busy", o_busy, 0);
    check("t6_ctl_count", ctl_addr_q.size(), 2);
    if (ctl_addr_q.size() == 2) check("t6_abort_cyc", ctl_cyc_q[1], n0 + 11);
    check("t6_ram_count", ram_addr_q.size(), 0);
    check("t6_no_done", done_n, 0);
`else
    repeat (100) @(negedge clk);
    check("t6_busy", o_busy, 1);
    check("t6_err", o_err, 0);
    check("t6_ready", o_cfg_ready, 1);
    check("t6_ctl_count", ctl_addr_q.size(), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_idle("t6_idle");
    check("t6_abort_err", o_err, 1);
    check("t6_abort_ctl", ctl_addr_q.size(), 2);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dec_cfg_seq.md
Name: dec_cfg_seq

Overview:
- Configuration sequencer for the semaphore decoder block.
- On a start request it safely stops the semaphore and streams ENTRIES period words from a valid/ready source into the period RAM slave.
- It then programs the divider register and re-enables run via the control slave.
- Sits between a configuration source (DMA/loader) and the decoder's control and memory slaves; sole master of both during a load.

Parameters:
- M, 32, period word width (matches decoder divisor width)
- ENTRIES, 16, number of period RAM words written per load
- AW, $clog2(ENTRIES), period RAM address width
- TIMEOUT, 1024, LOAD-state stall limit in cycles (used only with DEC_SEQ_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- clrn  in  1  reset: synchronous, active-high (clears on posedge clk while clrn=1)
- start  in  1  single-cycle load request
- abort  in  1  single-cycle abort request
- div_sel  in  2  divider value to program; sampled on accepted start
- cfg_data  in  M  period word stream data
- cfg_valid  in  1  stream valid
- cfg_ready  out  1  stream ready
- ctl_wr  out  1  control slave write strobe
- ctl_addr  out  1  control slave address: 0=run, 1=divider
- ctl_wrdata  out  32  control slave write data
- ram_wr  out  1  period RAM write strobe
- ram_addr  out  AW  period RAM address
- ram_wrdata  out  M  period RAM write data
- busy  out  1  high whenever the FSM is not in IDLE
- done  out  1  single-cycle pulse on successful completion
- err  out  1  sticky error flag; cleared by the next accepted start

Behaviour:
- Reset values: all outputs 0; state IDLE; index 0.
- All write-side outputs are registered. Each strobe is high for exactly one cycle per write, with addr/data valid in the same cycle.
- FSM states: IDLE, STOP, LOAD, DIV, RUN, DONE, ABORT.
- IDLE: start && !abort → STOP. Start is accepted only in IDLE; start while busy is ignored.
  - On acceptance: div_sel is latched, err is cleared, index = 0.
- STOP: one ctl write (addr 0, data 0), then → LOAD.
  - Timing: start at cycle N gives ctl_wr=1 at N+1.
- LOAD: cfg_ready=1.
  - A beat is accepted when cfg_valid && cfg_ready.
  - Beat accepted at cycle k gives ram_wr=1, ram_addr=index, ram_wrdata=cfg_data at k+1. Index then increments.
  - After the beat with index ENTRIES-1 is accepted: cfg_ready drops in the next cycle and the state → DIV. No wrap; extra source beats are not consumed.
  - cfg_ready is 0 in every state except LOAD.
- DIV: one ctl write (addr 1, data {30'b0, div_sel_latched}), then → RUN.
- RUN: one ctl write (addr 0, data 1), then → DONE.
- DONE: done=1 for one cycle, then → IDLE.
- Abort: in any state other than IDLE/ABORT, abort → ABORT.
  - Any write already registered for that cycle still completes; no further RAM writes.
  - ABORT issues one ctl write (addr 0, data 0), sets err=1, then → IDLE.
  - done is not pulsed. RAM contents are partial and undefined.
  - Abort in IDLE is a no-op, including when start is asserted in the same cycle.
- Abort arriving in the same cycle as the last LOAD beat: the beat's RAM write still issues, then → ABORT.
- Reset mid-operation: the FSM returns to IDLE immediately and outputs go to 0. No further writes. The decoder's own reset governs run.
- Latency of a full load with no stalls: ENTRIES + 5 cycles from start to done.

Optional Feature:
- Macro: DEC_SEQ_TIMEOUT_EN.
- With the macro defined:
  - A stall counter increments each LOAD cycle without an accepted beat and resets to 0 on every accepted beat.
  - Reaching TIMEOUT takes the same path as abort (→ ABORT, err=1).
- Without the macro: LOAD waits indefinitely; no counter logic is present.

Decomposition:
- Package dec_seq_pkg holds:
  - state enum type dec_seq_state_t
  - constants CTL_ADDR_RUN=1'b0, CTL_ADDR_DIV=1'b1
  - run on/off data constants
- One natural sub-module: dec_seq_timer (stall counter with clear/enable/expired), instantiated only under DEC_SEQ_TIMEOUT_EN.

Test Plan:
- Reset, then start with div_sel=2 and 16 back-to-back beats 0x10..0x1F → ctl write run=0 at N+1; ram_wr addr 0..15 with data 0x10..0x1F; ctl write divider=2; ctl write run=1; done pulse at N+21; err=0.
- Same load with cfg_valid toggling every other cycle → identical write sequence, each ram_wr one cycle after its accepted beat; done after 31+ cycles; busy high throughout.
- Abort after 5 beats → exactly 5 ram_wr (addr 0..4), then ctl write run=0, err=1, no done, no divider/run=1 writes; next start clears err.
- Start pulsed during LOAD and start+abort in IDLE → both ignored: no extra writes, state unchanged.
- clrn asserted mid-LOAD at beat 7 → next cycle all strobes 0, busy=0, cfg_ready=0; new start runs a full clean sequence.
- With DEC_SEQ_TIMEOUT_EN and TIMEOUT=8: cfg_valid held low in LOAD for 8 cycles → ABORT path, err=1. Without the macro: no abort after 100 cycles.
